// File: rtl/regfile_access_ctrl.sv
// Register-file access sequencer: core write-back, debug host, clear sequence.
// Optional debug write protection: define RFCTRL_WRITE_PROTECT_EN.
module regfile_access_ctrl #(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] CLR_VALUE = '0,
  parameter logic [XLEN-1:0] SP_INIT   = XLEN'(32'h0000_0FFC)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            cpu_halted,
  input  logic            cpu_we,
  input  logic [4:0]      cpu_rd,
  input  logic [XLEN-1:0] cpu_wdata,
  input  logic [4:0]      cpu_rs2,
  output logic            rf_we,
  output logic [4:0]      rf_rd,
  output logic [XLEN-1:0] rf_wdata,
  output logic [4:0]      rf_rs2,
  input  logic [XLEN-1:0] rf_rdata2,
  input  logic            dbg_valid,
  output logic            dbg_ready,
  input  logic            dbg_write,
  input  logic [4:0]      dbg_addr,
  input  logic [XLEN-1:0] dbg_wdata,
  output logic            dbg_rsp_valid,
  input  logic            dbg_rsp_ready,
  output logic [XLEN-1:0] dbg_rsp_data,
  input  logic            clr_start,
`ifdef RFCTRL_WRITE_PROTECT_EN
  input  logic [31:0]     wp_mask,
  output logic            dbg_rsp_err,
`endif
  output logic            clr_busy,
  output logic            clr_done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DBG_RD,
    S_DBG_WR,
    S_RSP,
    S_CLEAR
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [4:0]      r_addr;
  logic [XLEN-1:0] r_wdata;
  logic [XLEN-1:0] r_rdata;
  logic [4:0]      r_idx;
  logic            r_clr_done;
  logic            w_wp_hit;
  logic            w_accept;
  logic            w_clr_go;

`ifdef RFCTRL_WRITE_PROTECT_EN
  logic r_err;
  assign w_wp_hit    = wp_mask[r_addr];
  assign dbg_rsp_err = r_err;
`else
  assign w_wp_hit = 1'b0;
`endif

  assign w_clr_go  = (r_state == S_IDLE) & cpu_halted & clr_start;
  assign dbg_ready = (r_state == S_IDLE) & cpu_halted & ~clr_start;
  assign w_accept  = dbg_valid & dbg_ready;

  assign rf_rs2        = (r_state == S_DBG_RD) ? r_addr : cpu_rs2;
  assign dbg_rsp_valid = (r_state == S_RSP);
  assign dbg_rsp_data  = r_rdata;
  assign clr_busy      = (r_state == S_CLEAR);
  assign clr_done      = r_clr_done;

  // Core write-back always owns the port; clear and debug retry.
  always_comb begin
    rf_we    = 1'b0;
    rf_rd    = cpu_rd;
    rf_wdata = cpu_wdata;
    if (cpu_we) begin
      rf_we = (cpu_rd != 5'd0);
    end else if (r_state == S_CLEAR) begin
      rf_we    = 1'b1;
      rf_rd    = r_idx;
      rf_wdata = (r_idx == 5'd2) ? SP_INIT : CLR_VALUE;
    end else if (r_state == S_DBG_WR) begin
      rf_we    = (r_addr != 5'd0) & ~w_wp_hit;
      rf_rd    = r_addr;
      rf_wdata = r_wdata;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (w_clr_go)
          w_state_nxt = S_CLEAR;
        else if (w_accept)
          w_state_nxt = dbg_write ? S_DBG_WR : S_DBG_RD;
      end
      S_DBG_RD: w_state_nxt = S_RSP;
      S_DBG_WR: if (!cpu_we) w_state_nxt = S_RSP;
      S_RSP:    if (dbg_rsp_ready) w_state_nxt = S_IDLE;
      S_CLEAR:  if (!cpu_we && r_idx == 5'd31) w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_rdata    <= '0;
      r_idx      <= '0;
      r_clr_done <= 1'b0;
`ifdef RFCTRL_WRITE_PROTECT_EN
      r_err      <= 1'b0;
`endif
    end else begin
      r_state    <= w_state_nxt;
      r_clr_done <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (w_clr_go) begin
            r_idx <= 5'd1;
          end else if (w_accept) begin
            r_addr  <= dbg_addr;
            r_wdata <= dbg_wdata;
          end
        end
        S_DBG_RD: begin
          r_rdata <= (r_addr == 5'd0) ? '0 : rf_rdata2;
`ifdef RFCTRL_WRITE_PROTECT_EN
          r_err   <= 1'b0;
`endif
        end
        S_DBG_WR: begin
          if (!cpu_we) begin
            r_rdata <= '0;
`ifdef RFCTRL_WRITE_PROTECT_EN
            r_err   <= w_wp_hit;
`endif
          end
        end
        S_CLEAR: begin
          if (!cpu_we) begin
            r_idx <= r_idx + 5'd1;
            if (r_idx == 5'd31)
              r_clr_done <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/regfile_access_ctrl.md
Name: regfile_access_ctrl

Overview:
- Sequences access to the 32x32 register file for two non-core agents: a debug host (single-register read/write with valid/ready handshake) and a clear sequencer (initialises x1..x31).
- Sits between the core datapath and the register file and owns the file's write port and rs2 read-address mux.
- The core write-back always has priority.
- Debug and clear operations may only start while the core is halted.

Parameters:
- XLEN, 32, data width of the register file and all data ports.
- CLR_VALUE, 32'h0000_0000, value written to every register by the clear sequence except x2.
- SP_INIT, 32'h0000_0FFC, value written to x2 (stack pointer) by the clear sequence.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- cpu_halted  in  1  core halted; gates the start of debug and clear operations.
- cpu_we  in  1  core write-back enable (RUWr from the core).
- cpu_rd  in  5  core destination register.
- cpu_wdata  in  XLEN  core write-back data.
- cpu_rs2  in  5  core rs2 read address.
- rf_we  out  1  register-file write enable.
- rf_rd  out  5  register-file write address.
- rf_wdata  out  XLEN  register-file write data.
- rf_rs2  out  5  register-file rs2 read address.
- rf_rdata2  in  XLEN  register-file rs2 read data (asynchronous read).
- dbg_valid  in  1  debug request valid.
- dbg_ready  out  1  debug request accepted this cycle.
- dbg_write  in  1  1 = write, 0 = read.
- dbg_addr  in  5  debug register index.
- dbg_wdata  in  XLEN  debug write data.
- dbg_rsp_valid  out  1  debug response valid.
- dbg_rsp_ready  in  1  host accepts the response.
- dbg_rsp_data  out  XLEN  read data; 0 for writes.
- clr_start  in  1  start the clear sequence (level-sampled in IDLE).
- clr_busy  out  1  clear sequence in progress.
- clr_done  out  1  one-cycle pulse after the last clear write.

Behaviour:
- Reset (async, rst_n=0):
  - State = IDLE.
  - dbg_rsp_valid=0, dbg_rsp_data=0, clr_busy=0, clr_done=0.
  - Internal address and data registers = 0.
- States: IDLE, DBG_RD, DBG_WR, RSP, CLEAR.
- Write-port priority each cycle: cpu_we, then CLEAR, then DBG_WR.
  - If cpu_we=1: rf_we=(cpu_rd!=0), rf_rd=cpu_rd, rf_wdata=cpu_wdata. Any pending clear or debug write stalls and retries next cycle.
- rf_rs2 = latched debug address in DBG_RD; otherwise rf_rs2 = cpu_rs2.
- IDLE transitions:
  - If cpu_halted & clr_start: go to CLEAR with index=1. Clear wins over a simultaneous dbg_valid.
  - dbg_ready = (state==IDLE) & cpu_halted & !clr_start (combinational).
  - On dbg_valid&dbg_ready: latch dbg_addr, dbg_wdata, dbg_write, then go to DBG_WR or DBG_RD.
- DBG_RD (1 cycle):
  - Capture rdata = (addr==0) ? 0 : rf_rdata2. The register file has no reset, so x0 is forced to 0 here.
  - Go to RSP.
- DBG_WR:
  - When the port is free, issue rf_we=(addr!=0), rf_rd=addr, rf_wdata=latched data, then go to RSP.
  - A write to x0 is dropped but still acknowledged.
- RSP:
  - dbg_rsp_valid=1, dbg_rsp_data held stable until dbg_rsp_ready=1, then return to IDLE.
- Debug latency with no conflicts: accept at cycle T, rsp_valid at T+2.
- CLEAR:
  - clr_busy=1.
  - Each cycle the port is free, write index (x2 gets SP_INIT, all others CLR_VALUE), then increment index.
  - After writing x31: clr_done pulses for 1 cycle, clr_busy=0, state returns to IDLE.
  - Total 31 cycles with no stalls.
  - clr_start is ignored outside IDLE.
- cpu_halted deasserting mid-operation does not abort: the operation completes, yielding the write port to cpu_we.
- rst_n asserted mid-operation aborts immediately.
  - A partially completed clear leaves the registers already written unchanged; no clr_done is produced.
  - A pending debug response is discarded.

Optional Feature:
- Macro: RFCTRL_WRITE_PROTECT_EN.
- Enabled:
  - Adds input wp_mask [31:0] and output dbg_rsp_err (1).
  - A debug write to register i with wp_mask[i]=1 is dropped (no rf_we) and answered with dbg_rsp_err=1.
  - dbg_rsp_err is valid with dbg_rsp_valid and reset value 0.
  - The clear sequence and the core ignore wp_mask.
- Disabled: the port and mask logic are absent, and all debug writes proceed as normal.

Test Plan:
- Reset, then cpu_halted=1, debug write x5=32'hDEADBEEF, then debug read x5 -> write ack at T+2 with data 0; read returns 32'hDEADBEEF at T+2.
- Halted, debug write x0=32'h1234, then read x0 -> rf_we never asserted; read returns 0.
- Debug write x7 while cpu_we=1 to x9 on the same and following cycle -> core write lands first, x7 written the cycle after cpu_we drops, rsp delayed accordingly.
- clr_start with cpu_halted=1 -> 31 writes; x2=32'h0FFC, x1 and x3..x31=0; clr_done pulses once; clr_busy high for exactly 31 cycles.
- dbg_valid and clr_start together in IDLE -> dbg_ready=0, clear runs first, debug accepted after clr_done.
- Hold dbg_rsp_ready=0 for 5 cycles after a read -> dbg_rsp_valid and data remain stable, no new request accepted; reset mid-CLEAR at index 10 -> outputs return to reset values asynchronously.
